// File: rtl/coredma_buf_pkg.sv
// Shared constants for the DMA buffer FIFO controller.
// Output-stage state encoding and depth.
package coredma_buf_pkg;

    localparam logic [1:0] OUT_EMPTY = 2'd0;
    localparam logic [1:0] OUT_ONE   = 2'd1;
    localparam logic [1:0] OUT_TWO   = 2'd2;

    localparam int OUT_STAGE_DEPTH = 2;

endpackage

// File: rtl/coredma_buf_skid.sv
// Two-entry output stage (head + skid) behind the buffer RAM.
// Presents a first-word-fall-through stream from the head register.
module coredma_buf_skid
    import coredma_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            occ
);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  pop_ok;

    assign pop_ok = pop & valid;

    // Next-state: returning data goes to head when the stage is (or becomes) empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OUT_EMPTY;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (load) begin
                        head_d  = load_data;
                        state_d = OUT_ONE;
                    end
                end
                OUT_ONE: begin
                    case ({load, pop_ok})
                        2'b10: begin
                            skid_d  = load_data;
                            state_d = OUT_TWO;
                        end
                        2'b01: state_d = OUT_EMPTY;
                        2'b11: head_d = load_data;
                        default: state_d = OUT_ONE;
                    endcase
                end
                OUT_TWO: begin
                    if (pop_ok) begin
                        head_d  = skid_q;
                        state_d = OUT_ONE;
                    end
                end
                default: state_d = OUT_EMPTY;
            endcase
        end
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Occupancy as a count for the issue rule and status.
    always_comb begin
        occ = 2'd0;
        case (state_q)
            OUT_ONE: occ = 2'd1;
            OUT_TWO: occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign valid = (state_q != OUT_EMPTY);
    assign data  = head_q;

endmodule

// File: rtl/coredma_buf_fifo_ctrl.sv
// FIFO controller in front of the DMA cache buffer RAM.
// Pointers, committed-word count, read issue and status.
module coredma_buf_fifo_ctrl
    import coredma_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  SRST,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RAM_WEN,
    output logic [ADDR_WIDTH-1:0] RAM_WADDR,
    output logic [DATA_WIDTH-1:0] RAM_WDATA,
    output logic                  RAM_REN,
    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    input  logic [DATA_WIDTH-1:0] RAM_RDATA,
    output logic [ADDR_WIDTH+1:0] COUNT,
    output logic                  FULL,
    output logic                  EMPTY
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            pend;

    assign pop = RD_VALID & RD_READY;

    // Write acceptance passes straight through to the RAM write port.
    always_comb begin
        WR_READY  = (ram_cnt_q < DEPTH) & ~SRST;
        RAM_WEN   = WR_VALID & WR_READY;
        RAM_WADDR = wptr_q;
        RAM_WDATA = WR_DATA;
    end

    // Issue a read only if the stage has room once this cycle's pop and return settle.
    always_comb begin
        pend      = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight_q};
        RAM_REN   = (ram_cnt_q != '0) & (pend < 3'(OUT_STAGE_DEPTH)) & ~SRST;
        RAM_RADDR = rptr_q;
    end

    // Pointer, count and in-flight bookkeeping; flush wins over traffic.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = RAM_REN;
        if (SRST) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
        end else begin
            if (RAM_WEN) wptr_d = wptr_q + PTR_ONE;
            if (RAM_REN) rptr_d = rptr_q + PTR_ONE;
            case ({RAM_WEN, RAM_REN})
                2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
                2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
                default: ram_cnt_d = ram_cnt_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    coredma_buf_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .flush     (SRST),
        .load      (inflight_q),
        .load_data (RAM_RDATA),
        .pop       (pop),
        .valid     (RD_VALID),
        .data      (RD_DATA),
        .occ       (occ)
    );

    // Status from registered terms only.
    always_comb begin
        COUNT = {1'b0, ram_cnt_q}
              + {{ADDR_WIDTH{1'b0}}, occ}
              + {{(ADDR_WIDTH+1){1'b0}}, inflight_q};
        FULL  = (ram_cnt_q == DEPTH);
        EMPTY = (COUNT == '0);
    end

    // The issue rule must never overcommit the two-entry stage.
    a_stage_room: assert property (
        @(posedge CLOCK) disable iff (!RESET_N)
        ({1'b0, occ} + {2'b0, inflight_q}) <= 3'd2
    );

endmodule

// File: tb/tb_coredma_buf_fifo_ctrl.sv
// Bench for coredma_buf_fifo_ctrl: queue-based reference model,
// per-cycle compare process, directed and random traffic.
module tb_coredma_buf_fifo_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          srst = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_valid, ram_wen, ram_ren, full, empty;
    logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [AW+1:0] count;

    logic [DW-1:0] mem [DEPTH];

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] ramq [$];
    logic [DW-1:0] flyq [$];
    logic [DW-1:0] outq [$];
    int wcnt = 0;
    int rcnt = 0;

    coredma_buf_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLOCK     (clk),
        .RESET_N   (rst_n),
        .SRST      (srst),
        .WR_VALID  (wr_valid),
        .WR_READY  (wr_ready),
        .WR_DATA   (wr_data),
        .RD_VALID  (rd_valid),
        .RD_READY  (rd_ready),
        .RD_DATA   (rd_data),
        .RAM_WEN   (ram_wen),
        .RAM_WADDR (ram_waddr),
        .RAM_WDATA (ram_wdata),
        .RAM_REN   (ram_ren),
        .RAM_RADDR (ram_raddr),
        .RAM_RDATA (ram_rdata),
        .COUNT     (count),
        .FULL      (full),
        .EMPTY     (empty)
    );

    always #5 clk = ~clk;

    // Buffer RAM: 1R1W, registered read.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    task automatic cmpb(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cmpn(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cmpd(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic m_wr_ready();
        return (ramq.size() < DEPTH) && !srst;
    endfunction

    function automatic logic m_pop();
        return (outq.size() > 0) && rd_ready;
    endfunction

    // Read may go out if something is committed and the stage has a free slot
    // after this cycle's pop, counting the word already on its way.
    function automatic logic m_ren();
        int room_used;
        room_used = outq.size() - (m_pop() ? 1 : 0) + flyq.size();
        return (ramq.size() != 0) && (room_used < 2) && !srst;
    endfunction

    task automatic model_clear();
        ramq.delete();
        flyq.delete();
        outq.delete();
        wcnt = 0;
        rcnt = 0;
    endtask

    task automatic model_edge();
        logic pop, wen, ren;
        if (!rst_n || srst) begin
            model_clear();
            return;
        end
        pop = m_pop();
        wen = wr_valid && m_wr_ready();
        ren = m_ren();
        if (pop) void'(outq.pop_front());
        if (flyq.size() > 0) outq.push_back(flyq.pop_front());
        if (ren) begin
            flyq.push_back(ramq.pop_front());
            rcnt++;
        end
        if (wen) begin
            ramq.push_back(wr_data);
            wcnt++;
        end
    endtask

    task automatic check_outputs();
        int tot;
        tot = ramq.size() + flyq.size() + outq.size();
        cmpb("wr_ready", wr_ready, m_wr_ready());
        cmpb("ram_wen", ram_wen, wr_valid && m_wr_ready());
        cmpn("ram_waddr", int'(ram_waddr), wcnt % DEPTH);
        if (wr_valid && m_wr_ready()) cmpd("ram_wdata", ram_wdata, wr_data);
        cmpb("ram_ren", ram_ren, m_ren());
        cmpn("ram_raddr", int'(ram_raddr), rcnt % DEPTH);
        cmpb("rd_valid", rd_valid, outq.size() > 0);
        if (outq.size() > 0) cmpd("rd_data", rd_data, outq[0]);
        cmpn("count", int'(count), tot);
        cmpb("full", full, ramq.size() == DEPTH);
        cmpb("empty", empty, tot == 0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        #2;
        check_outputs();
    end

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic rr, input logic sr);
        @(negedge clk);
        wr_valid = v;
        wr_data  = d;
        rd_ready = rr;
        srst     = sr;
    endtask

    initial begin
        int acc, npop, first, last;
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};

        repeat (3) @(negedge clk);
        #3;
        cmpb("rst_wr_ready", wr_ready, 1'b1);
        cmpb("rst_rd_valid", rd_valid, 1'b0);
        cmpb("rst_empty", empty, 1'b1);
        cmpn("rst_count", int'(count), 0);
        cmpb("rst_ram_wen", ram_wen, 1'b0);
        cmpb("rst_ram_ren", ram_ren, 1'b0);
        cmpd("rst_rd_data", rd_data, '0);
        cmpb("rst_full", full, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single word latency
        drive(1'b1, a5, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("lat_ren_c1", ram_ren, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("lat_novalid_c2", rd_valid, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3;
        cmpb("lat_valid_c3", rd_valid, 1'b1);
        cmpd("lat_data_c3", rd_data, a5);
        drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("lat_empty_c4", empty, 1'b1);

        // fill with consumer stalled
        acc = 0;
        for (int i = 0; i < 131; i++) begin
            drive(1'b1, rnd(), 1'b0, 1'b0);
            #1;
            if (wr_ready) acc++;
        end
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        cmpn("fill_accepted", acc, 130);
        cmpn("fill_count", int'(count), 130);
        cmpb("fill_full", full, 1'b1);
        cmpb("fill_wr_ready", wr_ready, 1'b0);
        repeat (140) drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("fill_drained", empty, 1'b1);

        // streaming through pointer wrap
        npop  = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < 310; i++) begin
            drive(i < 300, rnd(), 1'b1, 1'b0);
            #1;
            if (rd_valid) begin
                if (first < 0) first = i;
                last = i;
                npop++;
            end
        end
        cmpn("stream_pops", npop, 300);
        cmpn("stream_first", first, 3);
        cmpn("stream_nogap", last - first, 299);

        // random traffic with backpressure
        for (int i = 0; i < 800; i++)
            drive(1'($urandom_range(0, 3) != 0), rnd(),
                  1'($urandom_range(0, 1)), 1'b0);
        repeat (150) drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("rand_drained", empty, 1'b1);

        // synchronous flush with words held and a read in flight
        repeat (7) drive(1'b1, rnd(), 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, rnd(), 1'b1, 1'b1);
        #3;
        cmpb("srst_wr_ready", wr_ready, 1'b0);
        cmpn("srst_held", int'(count), 6);
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        cmpn("srst_count", int'(count), 0);
        cmpb("srst_rd_valid", rd_valid, 1'b0);
        repeat (4) drive(1'b1, rnd(), 1'b1, 1'b0);
        repeat (8) drive(1'b0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 20; i++)
            drive(1'b1, rnd(), 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        cmpn("arst_count", int'(count), 0);
        cmpb("arst_rd_valid", rd_valid, 1'b0);
        cmpb("arst_empty", empty, 1'b1);
        cmpb("arst_wr_ready", wr_ready, 1'b1);
        cmpb("arst_ram_ren", ram_ren, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(1'b1, rnd(), 1'b1, 1'b0);
        repeat (10) drive(1'b0, '0, 1'b1, 1'b0);
        #3 cmpb("arst_after_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
